clk_div: RTL and testbench



---
 rtl/clk_div.sv | 45 ++++
 tb/tb_clk_div.sv | 125 ++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Integer clock divider: clk_out is low for ceil(DIVISOR/2) and high for
// floor(DIVISOR/2) source cycles, and is driven straight from a flop.
module clk_div #(
    parameter int DIVISOR = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    localparam int CW          = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR);
    localparam int LOW_CYCLES  = (DIVISOR + 1) / 2;
    localparam int HIGH_CYCLES = DIVISOR / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(LOW_CYCLES);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("clk_div: DIVISOR must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
            cnt_n = '0;
        end
    end

    // The output flop looks ahead at cnt_n so clk_out and cnt stay in phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            clk_out <= (cnt_n >= CNT_RISE);
        end
    end

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: six divisors share clk/rst and are checked every cycle
// against an edges-since-release model, with directed phase/duty pins.
module tb_clk_div;

    localparam int N = 6;

    logic         clk;
    logic         rst;
    logic [N-1:0] co;

    int tests;
    int fails;
    bit model_on;

    clk_div #(.DIVISOR(2))   u2   (.clk(clk), .rst(rst), .clk_out(co[0]));
    clk_div #(.DIVISOR(4))   u4   (.clk(clk), .rst(rst), .clk_out(co[1]));
    clk_div #(.DIVISOR(5))   u5   (.clk(clk), .rst(rst), .clk_out(co[2]));
    clk_div #(.DIVISOR(6))   u6   (.clk(clk), .rst(rst), .clk_out(co[3]));
    clk_div #(.DIVISOR(8))   u8   (.clk(clk), .rst(rst), .clk_out(co[4]));
    clk_div #(.DIVISOR(868)) u868 (.clk(clk), .rst(rst), .clk_out(co[5]));

    int div_tab[N]        = '{2, 4, 5, 6, 8, 868};
    int first_rise_exp[N] = '{1, 2, 3, 3, 4, 434};
    int high_len_exp[N]   = '{1, 2, 2, 3, 4, 434};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k = rising edges since the last reset edge. After k edges the
    // divider sits at phase k mod D and is high once that phase reaches LOW.
    int k;
    initial k = 0;
    always @(negedge clk) begin
        if (rst) k = 0;
        else k = k + 1;
        if (model_on) begin
            for (int j = 0; j < N; j++) begin
                int d;
                int low;
                int exp_v;
                d     = div_tab[j];
                low   = (d + 1) / 2;
                exp_v = ((k % d) >= low) ? 1 : 0;
                check($sformatf("clk_out_div%0d", d), int'(co[j]), exp_v);
            end
            check("cnt868_in_range", (int'(u868.cnt) <= 867) ? 1 : 0, 1);
        end
    end

    task automatic hold_reset(input int cycles);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // driver / directed pins / random reset stress
    initial begin
        int first_rise[N];
        int high_len[N];
        bit fell[N];
        model_on = 1'b0;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        model_on = 1'b1;
        #1;
        check("reset_clk_out_all", int'(co), 0);
        rst = 1'b0;

        for (int j = 0; j < N; j++) begin
            first_rise[j] = -1;
            high_len[j]   = 0;
            fell[j]       = 1'b0;
        end
        for (int i = 1; i <= 1800; i++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < N; j++) begin
                if (co[j] && first_rise[j] < 0) first_rise[j] = i;
                if (first_rise[j] >= 0 && !fell[j]) begin
                    if (co[j]) high_len[j]++;
                    else fell[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            check($sformatf("first_rise_div%0d", div_tab[j]), first_rise[j], first_rise_exp[j]);
            check($sformatf("high_len_div%0d", div_tab[j]), high_len[j], high_len_exp[j]);
        end

        // Reset mid high phase of the 868 divider: output must drop at that edge.
        hold_reset(1);
        repeat (500) @(negedge clk);
        #1;
        check("div868_high_before_abort", int'(co[5]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_clk_out_all", int'(co), 0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int s = 0; s < 25; s++) begin
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            hold_reset($urandom_range(1, 4));
        end
        repeat (1000) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
